// File: rtl/a51_wb_multi.sv
// Multi-channel A5/1 keystream engine behind a Wishbone slave port.
// Each 32-byte window holds KEY, FRAME, CTRL/STATUS and a KS pop register.
module a51_wb_multi_ch (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_key_lo,
  input  logic        wr_key_hi,
  input  logic        wr_frame,
  input  logic        start,
  input  logic        rd_ks,
  input  logic [3:0]  sel,
  input  logic [31:0] wdat,
  output logic [63:0] key,
  output logic [21:0] frame,
  output logic [31:0] ks,
  output logic        busy,
  output logic        ready
);
  typedef enum logic [2:0] {
    S_IDLE, S_KEY, S_FRAME, S_MIX, S_GEN, S_READY
  } state_t;

  state_t      state_q, state_d;
  logic [6:0]  cnt_q, cnt_d;
  logic [85:0] sh_q, sh_d;
  logic [18:0] r1_q, r1_d, r1_n;
  logic [21:0] r2_q, r2_d, r2_n;
  logic [22:0] r3_q, r3_d, r3_n;
  logic [31:0] gen_q, gen_d;
  logic [31:0] ks_q, ks_d;
  logic [63:0] key_q, key_d;
  logic [21:0] frame_q, frame_d;
  logic        full, run, ld, maj, ob;

  assign full = (state_q == S_KEY) || (state_q == S_FRAME);
  assign run  = full || (state_q == S_MIX) || (state_q == S_GEN);
  assign ld   = full & sh_q[0];
  assign maj  = (r1_q[8] & r2_q[10]) | (r1_q[8] & r3_q[10])
              | (r2_q[10] & r3_q[10]);

  // Load phases clock every register; mix/gen use majority clocking.
  assign r1_n = (full || r1_q[8] == maj)
    ? {r1_q[17:0], r1_q[13] ^ r1_q[16] ^ r1_q[17] ^ r1_q[18] ^ ld}
    : r1_q;
  assign r2_n = (full || r2_q[10] == maj)
    ? {r2_q[20:0], r2_q[20] ^ r2_q[21] ^ ld}
    : r2_q;
  assign r3_n = (full || r3_q[10] == maj)
    ? {r3_q[21:0], r3_q[7] ^ r3_q[20] ^ r3_q[21] ^ r3_q[22] ^ ld}
    : r3_q;
  assign ob = r1_n[18] ^ r2_n[21] ^ r3_n[22];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    r1_d    = r1_q;
    r2_d    = r2_q;
    r3_d    = r3_q;
    gen_d   = gen_q;
    ks_d    = ks_q;
    key_d   = key_q;
    frame_d = frame_q;
    for (int b = 0; b < 4; b++) begin
      if (wr_key_lo && sel[b]) key_d[8*b +: 8] = wdat[8*b +: 8];
      if (wr_key_hi && sel[b]) key_d[32+8*b +: 8] = wdat[8*b +: 8];
    end
    if (wr_frame && sel[0]) frame_d[7:0]   = wdat[7:0];
    if (wr_frame && sel[1]) frame_d[15:8]  = wdat[15:8];
    if (wr_frame && sel[2]) frame_d[21:16] = wdat[21:16];
    if (run) begin
      r1_d  = r1_n;
      r2_d  = r2_n;
      r3_d  = r3_n;
      cnt_d = cnt_q + 7'd1;
    end
    if (full) sh_d = sh_q >> 1;
    unique case (state_q)
      S_KEY: if (cnt_q == 7'd63) begin
        state_d = S_FRAME;
        cnt_d   = '0;
      end
      S_FRAME: if (cnt_q == 7'd21) begin
        state_d = S_MIX;
        cnt_d   = '0;
      end
      S_MIX: if (cnt_q == 7'd99) begin
        state_d = S_GEN;
        cnt_d   = '0;
      end
      S_GEN: begin
        gen_d = {gen_q[30:0], ob};
        if (cnt_q == 7'd31) begin
          state_d = S_READY;
          cnt_d   = '0;
          ks_d    = {gen_q[30:0], ob};
        end
      end
      S_READY: if (rd_ks) begin
        state_d = S_GEN;
        cnt_d   = '0;
      end
      default: ;
    endcase
    // Start snapshots KEY/FRAME so later writes only affect the next run.
    if (start) begin
      state_d = S_KEY;
      cnt_d   = '0;
      sh_d    = {frame_q, key_q};
      r1_d    = '0;
      r2_d    = '0;
      r3_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      r1_q    <= '0;
      r2_q    <= '0;
      r3_q    <= '0;
      gen_q   <= '0;
      ks_q    <= '0;
      key_q   <= '0;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      r1_q    <= r1_d;
      r2_q    <= r2_d;
      r3_q    <= r3_d;
      gen_q   <= gen_d;
      ks_q    <= ks_d;
      key_q   <= key_d;
      frame_q <= frame_d;
    end
  end

  assign key   = key_q;
  assign frame = frame_q;
  assign ks    = ks_q;
  assign busy  = run;
  assign ready = (state_q == S_READY);
endmodule

module a51_wb_multi #(
  parameter int          NUM_CH         = 2,
  parameter logic [31:0] BASE_ADDR      = 32'h3000_0000,
  parameter int          CH_STRIDE_LOG2 = 5
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_n_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  output logic [NUM_CH-1:0] irq_o
);
  logic        ack_q, ack_d;
  logic [31:0] dat_q, dat_d;
  logic [31:0] rdata;
  logic        hit, req, ch_ok;
  logic [2:0]  ch_idx, off;
  logic        unused_ok;

  logic [63:0]       key_w   [NUM_CH];
  logic [21:0]       frame_w [NUM_CH];
  logic [31:0]       ks_w    [NUM_CH];
  logic [NUM_CH-1:0] busy_w, ready_w;

  assign hit    = wbs_adr_i[31:8] == BASE_ADDR[31:8];
  assign req    = wbs_stb_i & wbs_cyc_i & ~ack_q & hit;
  assign ch_idx = wbs_adr_i[CH_STRIDE_LOG2 +: 3];
  assign off    = wbs_adr_i[4:2];
  assign ch_ok  = int'(ch_idx) < NUM_CH;
  assign unused_ok = ^wbs_adr_i[1:0];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic sel_ch, wr, rd;
    assign sel_ch = req & ch_ok & (ch_idx == 3'(g));
    assign wr     = sel_ch & wbs_we_i;
    assign rd     = sel_ch & ~wbs_we_i;
    a51_wb_multi_ch u_ch (
      .clk       (wb_clk_i),
      .rst_n     (wb_rst_n_i),
      .wr_key_lo (wr & (off == 3'd0)),
      .wr_key_hi (wr & (off == 3'd1)),
      .wr_frame  (wr & (off == 3'd2)),
      .start     (wr & (off == 3'd3) & wbs_sel_i[0] & wbs_dat_i[0]),
      .rd_ks     (rd & (off == 3'd4)),
      .sel       (wbs_sel_i),
      .wdat      (wbs_dat_i),
      .key       (key_w[g]),
      .frame     (frame_w[g]),
      .ks        (ks_w[g]),
      .busy      (busy_w[g]),
      .ready     (ready_w[g])
    );
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_idx == 3'(i)) begin
        unique case (1'b1)
          off == 3'd0: rdata = key_w[i][31:0];
          off == 3'd1: rdata = key_w[i][63:32];
          off == 3'd2: rdata = {10'd0, frame_w[i]};
          off == 3'd3: rdata = {30'd0, ready_w[i], busy_w[i]};
          off == 3'd4: rdata = ks_w[i];
          default:     rdata = '0;
        endcase
      end
    end
    ack_d = req;
    dat_d = (req && !wbs_we_i && ch_ok) ? rdata : '0;
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      ack_q <= 1'b0;
      dat_q <= '0;
    end else begin
      ack_q <= ack_d;
      dat_q <= dat_d;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign irq_o     = ready_w;
endmodule
